// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide family.
// Contents:
//   mul_state_e    - controller state encoding (IDLE/RUN/FIX/OUT)
//   MUL_WIDTH_MIN  - smallest supported operand width
//   MUL_WIDTH_MAX  - largest supported operand width
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } mul_state_e;

  localparam int MUL_WIDTH_MIN = 2;
  localparam int MUL_WIDTH_MAX = 32;

endpackage

// File: rtl/mul_abs_neg.sv
// Conditional two's-complement negate, purely combinational.
// Used for operand magnitudes (neg = operand sign) and for the final
// product sign fix (neg = sign of the result).
// Ports:
//   value_i  [W-1:0]  input value
//   neg_i             1 = output the two's-complement negation
//   result_o [W-1:0]  value_i or -value_i, modulo 2^W
// Negating the most negative value wraps to itself, which read as an
// unsigned number is exactly its magnitude, so no extra bit is needed.
module mul_abs_neg
  import mul_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] value_i,
  input  logic         neg_i,
  output logic [W-1:0] result_o
);

  assign result_o = neg_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/param_seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle.
// Operands are converted to magnitudes at capture, multiplied unsigned,
// and the sign is reapplied in a single FIX cycle.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (ready only in IDLE)
//   a, b [WIDTH-1:0]     multiplicand, multiplier
//   signed_mode          1 = two's-complement operands
//   out_valid/out_ready  result handshake (result held until accepted)
//   product [2*WIDTH-1:0]
//   busy                 high whenever not IDLE
module param_seq_multiplier
  import mul_div_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  if (WIDTH < MUL_WIDTH_MIN || WIDTH > MUL_WIDTH_MAX) begin : g_bad_width
    $error("param_seq_multiplier: WIDTH outside supported range");
  end

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_signed;

  mul_abs_neg #(.W(WIDTH)) u_a_mag (
    .value_i  (a),
    .neg_i    (signed_mode & a[WIDTH-1]),
    .result_o (a_mag)
  );

  mul_abs_neg #(.W(WIDTH)) u_b_mag (
    .value_i  (b),
    .neg_i    (signed_mode & b[WIDTH-1]),
    .result_o (b_mag)
  );

  // Negating a zero accumulator yields zero, so a negative-signed zero
  // product cannot leak out.
  mul_abs_neg #(.W(2*WIDTH)) u_fix (
    .value_i  (acc_q),
    .neg_i    (sign_q),
    .result_o (acc_signed)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mode_q      <= 1'b0;
      sign_q      <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    mode_d      = mode_q;
    sign_d      = sign_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d   = signed_mode;
          sign_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q);
        end
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Stop once the last bit is consumed, or earlier when nothing
        // above the current bit can contribute any more.
        if (count_q == LAST_COUNT ||
            (EARLY_TERM != 0 && (mplier_q >> 1) == '0)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d   = acc_signed;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Two instances (early termination on / off) share one stimulus stream.
// A cycle-level reference model predicts handshake timing and results
// from plain arithmetic; a compare process checks every cycle, and the
// directed tests pin literal products and latencies.
module tb_param_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       signed_mode;
  logic       out_ready;

  logic [1:0]       in_ready_w, out_valid_w, busy_w;
  logic [1:0][15:0] product_w;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  param_seq_multiplier #(.WIDTH(8), .EARLY_TERM(1)) u_dut_et (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .product(product_w[0]), .busy(busy_w[0])
  );

  param_seq_multiplier #(.WIDTH(8), .EARLY_TERM(0)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .product(product_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, idx, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
    logic signed [15:0] sx, sy;
    if (s) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      return 16'(sx * sy);
    end
    return {8'd0, x} * {8'd0, y};
  endfunction

  // Cycles from capture to out_valid: 9 without early termination,
  // otherwise (index of highest set magnitude bit + 1, min 1) + 1.
  function automatic int ref_lat(input logic [7:0] y, input logic s, input bit et);
    logic [7:0] mb;
    int r;
    mb = (s && y[7]) ? (~y + 8'd1) : y;
    r = 1;
    for (int k = 0; k < 8; k++) if (mb[k]) r = k + 1;
    return et ? r + 1 : 9;
  endfunction

  bit          m_busy  [2];
  bit          m_valid [2];
  int          m_left  [2];
  logic [15:0] m_prod  [2];
  logic [15:0] m_out   [2];
  int          m_done  [2];
  int          dut_done[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_left[i]  <= 0;
        m_out[i]   <= '0;
      end else begin
        if (out_valid_w[i] && out_ready) dut_done[i] <= dut_done[i] + 1;
        if (!m_busy[i]) begin
          if (in_valid) begin
            m_busy[i] <= 1'b1;
            m_left[i] <= ref_lat(b, signed_mode, i == 0);
            m_prod[i] <= ref_mul(a, b, signed_mode);
          end
        end else if (!m_valid[i]) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_valid[i] <= 1'b1;
            m_out[i]   <= m_prod[i];
          end
        end else if (out_ready) begin
          m_valid[i] <= 1'b0;
          m_busy[i]  <= 1'b0;
          m_done[i]  <= m_done[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("cyc_in_ready", i, 32'(in_ready_w[i]), 32'(!m_busy[i]));
        chk("cyc_busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
        chk("cyc_out_valid", i, 32'(out_valid_w[i]), 32'(m_valid[i]));
        chk("cyc_product", i, 32'(product_w[i]), 32'(m_out[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (in_ready_w[0] && in_ready_w[1]) return;
      @(negedge clk);
    end
    chk("wait_idle_timeout", 0, 32'(in_ready_w), 32'h3);
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                        input logic [15:0] ep, input int el0, input int el1);
    int          lat [2];
    logic [15:0] got [2];
    bit          seen[2];
    wait_idle();
    a = ia; b = ib; signed_mode = s; in_valid = 1'b1;
    @(negedge clk);
    // Scramble operands right after capture; the result must not move.
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    seen = '{1'b0, 1'b0};
    lat  = '{-1, -1};
    got  = '{16'hxxxx, 16'hxxxx};
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (!seen[i] && out_valid_w[i]) begin
          seen[i] = 1'b1; lat[i] = c; got[i] = product_w[i];
        end
      end
      if (seen[0] && seen[1]) break;
    end
    $display("op a=0x%02h b=0x%02h s=%0d : et prod=0x%04h lat=%0d | nt prod=0x%04h lat=%0d",
             ia, ib, s, got[0], lat[0], got[1], lat[1]);
    chk("lit_product", 0, 32'(got[0]), 32'(ep));
    chk("lit_product", 1, 32'(got[1]), 32'(ep));
    chk("lit_latency", 0, 32'(lat[0]), 32'(el0));
    chk("lit_latency", 1, 32'(lat[1]), 32'(el1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; signed_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin m_done[i] = 0; dut_done[i] = 0; end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_product", i, 32'(product_w[i]), 32'h0);
      chk("rst_out_valid", i, 32'(out_valid_w[i]), 32'h0);
      chk("rst_in_ready", i, 32'(in_ready_w[i]), 32'h1);
      chk("rst_busy", i, 32'(busy_w[i]), 32'h0);
    end

    // Directed products: operands, signed, expected product, latency et/nt
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, 9);
    run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 4, 9);
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, 9, 9);
    run_op(8'h55, 8'h00, 1'b0, 16'h0000, 2, 9);
    run_op(8'h7F, 8'h01, 1'b0, 16'h007F, 2, 9);
    run_op(8'h00, 8'hFF, 1'b1, 16'h0000, 2, 9);
    run_op(8'h80, 8'h7F, 1'b1, 16'hC080, 8, 9);
    run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 2, 9);

    // Reset during the third RUN edge aborts without a result.
    wait_idle();
    a = 8'h03; b = 8'hFF; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-run reset: et out_valid=%0d prod=0x%04h | nt out_valid=%0d prod=0x%04h",
             out_valid_w[0], product_w[0], out_valid_w[1], product_w[1]);
    for (int i = 0; i < 2; i++) begin
      chk("abort_out_valid", i, 32'(out_valid_w[i]), 32'h0);
      chk("abort_product", i, 32'(product_w[i]), 32'h0);
      chk("abort_in_ready", i, 32'(in_ready_w[i]), 32'h1);
    end
    run_op(8'h06, 8'h07, 1'b0, 16'd42, 4, 9);

    // Backpressure: result held while out_ready is low, inputs ignored.
    wait_idle();
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid_w[1]) break;
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'(k & 1); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      $display("hold cycle %0d: et prod=0x%04h nt prod=0x%04h", k, product_w[0], product_w[1]);
      for (int i = 0; i < 2; i++) begin
        chk("hold_out_valid", i, 32'(out_valid_w[i]), 32'h1);
        chk("hold_product", i, 32'(product_w[i]), 32'h03A8);
        chk("hold_in_ready", i, 32'(in_ready_w[i]), 32'h0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("consume_out_valid", i, 32'(out_valid_w[i]), 32'h0);
      chk("consume_in_ready", i, 32'(in_ready_w[i]), 32'h1);
    end

    // Back-to-back with operands changing every cycle.
    in_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      $display("back-to-back dut%0d: results=%0d expected=%0d", i, dut_done[i], m_done[i]);
      chk("b2b_result_count", i, 32'(dut_done[i]), 32'(m_done[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
